fifo_pkt_reader: RTL and testbench

Read-side framer that sits directly downstream of the show-ahead `fifo` wrapper. It drains length-prefixed packets from the FIFO: each packet is one header word followed by N payload words. The block strips the header and presents the payload as a valid/ready stream with `sop`/`eop` framing. A 2-entry output buffer keeps `out_ready` out of the combinational path to `fifo_rdreq`.

---
 rtl/fifo_pkt_reader.sv | 133 +++++++++++++
 tb/tb_fifo_pkt_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader
//   Read-side framer behind a show-ahead FIFO. Each packet in the FIFO is one
//   header word (length in fifo_q[LW-1:0]) followed by that many payload words.
//   The header is stripped and the payload is presented as a valid/ready stream
//   with sop/eop. A 2-entry output buffer decouples out_ready from fifo_rdreq.
//
// Ports
//   clock, reset_n      clock, async active-low reset
//   sclr                synchronous flush of buffer and framing state
//   fifo_empty, fifo_q  show-ahead FIFO head
//   fifo_rdreq          pop FIFO head this cycle
//   out_valid/out_ready stream handshake; out_data/out_sop/out_eop = oldest entry
//   pkt_cnt             packets fully pushed into the buffer (wraps)
//   err_zero_len        one-cycle pulse, cycle after a zero-length header pop
module fifo_pkt_reader #(
    parameter int DW = 256,
    parameter int LW = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          sclr,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_q,
    output logic          fifo_rdreq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [31:0]   pkt_cnt,
    output logic          err_zero_len
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    localparam logic [0:0] ST_HDR = 1'b0;
    localparam logic [0:0] ST_PAY = 1'b1;

    logic [0:0]    state;
    logic [LW-1:0] remain;
    logic          first;
    logic [1:0]    occ;
    beat_t         ent0, ent1;   // ent0 is the oldest entry
    beat_t         new_beat;

    logic          hdr_st, hdr_pop, push, pop, last;
    logic [LW-1:0] hdr_len;

    assign hdr_st  = (state == ST_HDR);
    assign hdr_len = fifo_q[LW-1:0];
    assign last    = (remain == LW'(1));

    // Registered state and fifo_empty only; out_ready never reaches this path.
    // Headers bypass the buffer, so a header pop is allowed even at occ == 2.
    assign fifo_rdreq = reset_n && !sclr && !fifo_empty && (hdr_st || occ != 2'd2);
    assign hdr_pop    = fifo_rdreq && hdr_st;
    assign push       = fifo_rdreq && !hdr_st;
    assign pop        = out_valid && out_ready;

    always_comb begin
        new_beat      = '0;
        new_beat.data = fifo_q;
        new_beat.sop  = first;
        new_beat.eop  = last;
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = ent0.data;
    assign out_sop   = ent0.sop;
    assign out_eop   = ent0.eop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HDR;
            remain       <= '0;
            first        <= 1'b0;
            occ          <= 2'd0;
            ent0         <= '0;
            ent1         <= '0;
            pkt_cnt      <= '0;
            err_zero_len <= 1'b0;
        end else begin
            err_zero_len <= 1'b0;
            if (sclr) begin
                state  <= ST_HDR;
                remain <= '0;
                first  <= 1'b0;
                occ    <= 2'd0;
            end else begin
                if (hdr_pop) begin
                    if (hdr_len == '0) begin
                        err_zero_len <= 1'b1;
                    end else begin
                        remain <= hdr_len;
                        first  <= 1'b1;
                        state  <= ST_PAY;
                    end
                end
                if (push) begin
                    remain <= remain - LW'(1);
                    first  <= 1'b0;
                    if (last) begin
                        pkt_cnt <= pkt_cnt + 32'd1;
                        state   <= ST_HDR;
                    end
                end
                // Pop is applied before push so order holds at occ == 2.
                case ({push, pop})
                    2'b01: ent0 <= ent1;
                    2'b10: begin
                        if (occ == 2'd0) ent0 <= new_beat;
                        else             ent1 <= new_beat;
                    end
                    2'b11: begin
                        if (occ == 2'd1) begin
                            ent0 <= new_beat;
                        end else begin
                            ent0 <= ent1;
                            ent1 <= new_beat;
                        end
                    end
                    default: ;
                endcase
                occ <= occ + 2'(push) - 2'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;
    localparam int DW = 256;
    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sclr = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_q;
    logic          fifo_rdreq, out_valid, out_sop, out_eop, err_zero_len;
    logic [DW-1:0] out_data;
    logic [31:0]   pkt_cnt;

    always #5 clock = ~clock;

    fifo_pkt_reader #(.DW(DW), .LW(LW)) dut (
        .clock(clock), .reset_n(reset_n), .sclr(sclr),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .pkt_cnt(pkt_cnt),
        .err_zero_len(err_zero_len)
    );

    // Show-ahead FIFO model feeding the DUT
    logic [DW-1:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_q     = mem[rd_ptr % 64];
    always @(posedge clock) if (fifo_rdreq) rd_ptr <= rd_ptr + 1;

    // Output beat collector, sampled mid-cycle
    int            cyc = 0, rx_n = 0, err_n = 0;
    logic [DW-1:0] rx_data [64];
    logic          rx_sop  [64];
    logic          rx_eop  [64];
    int            rx_cyc  [64];
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            rx_data[rx_n % 64] <= out_data;
            rx_sop[rx_n % 64]  <= out_sop;
            rx_eop[rx_n % 64]  <= out_eop;
            rx_cyc[rx_n % 64]  <= cyc;
            rx_n               <= rx_n + 1;
        end
        if (err_zero_len) err_n <= err_n + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pw(input int k);
        return {8{32'hD00D_0000 + 32'(k)}};
    endfunction

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Header with all-ones upper bits: only the length field may matter.
    task automatic hdr(input int len);
        logic [DW-1:0] w;
        w = '1;
        w[LW-1:0] = LW'(len);
        push(w);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n, output int rd, output int vld, output int maxrun, output logic last_rd);
        int r;
        rd = 0; vld = 0; maxrun = 0; r = 0; last_rd = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            last_rd = fifo_rdreq;
            if (fifo_rdreq) begin
                rd++; r++;
                if (r > maxrun) maxrun = r;
            end else begin
                r = 0;
            end
            if (out_valid) vld++;
        end
    endtask

    task automatic chk_beat(input int idx, input logic [DW-1:0] d, input logic s, input logic e);
        chk($sformatf("beat%0d_data", idx), rx_data[idx % 64], d);
        chk($sformatf("beat%0d_sop", idx), rx_sop[idx % 64], s);
        chk($sformatf("beat%0d_eop", idx), rx_eop[idx % 64], e);
    endtask

    initial begin
        int   rd, vld, mr, base, eb;
        logic lr;

        // Reset, with a packet already waiting in the FIFO
        hdr(3); push(pw(1)); push(pw(2)); push(pw(3));
        out_ready = 1'b1;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sop", out_sop, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_zero_len, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        tick();
        reset_n = 1'b1;

        // Single length-3 packet, continuous ready
        run(8, rd, vld, mr, lr);
        tick();
        chk("p3_rdreq_total", rd, 4);
        chk("p3_rdreq_run", mr, 4);
        chk("p3_valid_cycles", vld, 3);
        chk("p3_beats", rx_n, 3);
        chk_beat(0, pw(1), 1, 0);
        chk_beat(1, pw(2), 0, 0);
        chk_beat(2, pw(3), 0, 1);
        chk("p3_pkt", pkt_cnt, 1);

        // Back-to-back lengths 1, 2, 1
        base = rx_n;
        hdr(1); push(pw(10));
        hdr(2); push(pw(11)); push(pw(12));
        hdr(1); push(pw(13));
        run(12, rd, vld, mr, lr);
        tick();
        chk("b2b_beats", rx_n - base, 4);
        chk_beat(base + 0, pw(10), 1, 1);
        chk_beat(base + 1, pw(11), 1, 0);
        chk_beat(base + 2, pw(12), 0, 1);
        chk_beat(base + 3, pw(13), 1, 1);
        chk("b2b_gap1", rx_cyc[(base + 1) % 64] - rx_cyc[base % 64], 2);
        chk("b2b_gap2", rx_cyc[(base + 3) % 64] - rx_cyc[(base + 2) % 64], 2);
        chk("b2b_pkt", pkt_cnt, 4);

        // Backpressure, length 5
        out_ready = 1'b0;
        base = rx_n;
        hdr(5);
        for (int k = 0; k < 5; k++) push(pw(20 + k));
        run(6, rd, vld, mr, lr);
        chk("bp_rdreq_total", rd, 3);
        chk("bp_rdreq_last", lr, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_data_held", out_data, pw(20));
        chk("bp_sop_held", out_sop, 1);
        tick();
        chk("bp_no_beats", rx_n - base, 0);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_rdreq_hold", fifo_rdreq, 0);
        @(negedge clock);
        chk("bp_rdreq_resume", fifo_rdreq, 1);
        run(10, rd, vld, mr, lr);
        tick();
        chk("bp_beats", rx_n - base, 5);
        for (int k = 0; k < 5; k++) chk_beat(base + k, pw(20 + k), k == 0, k == 4);
        chk("bp_pkt", pkt_cnt, 5);

        // Zero-length header, then length 2
        base = rx_n;
        eb = err_n;
        hdr(0); hdr(2); push(pw(30)); push(pw(31));
        run(10, rd, vld, mr, lr);
        tick();
        chk("zl_err_pulses", err_n - eb, 1);
        chk("zl_beats", rx_n - base, 2);
        chk_beat(base + 0, pw(30), 1, 0);
        chk_beat(base + 1, pw(31), 0, 1);
        chk("zl_pkt", pkt_cnt, 6);

        // Flush after two beats of a length-4 packet; the following word
        // (a length-1 header) must be parsed as a fresh header.
        out_ready = 1'b0;
        base = rx_n;
        hdr(4); push(pw(40)); push(pw(41)); hdr(1); push(pw(43));
        run(3, rd, vld, mr, lr);
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        @(negedge clock);
        chk("sclr_valid", out_valid, 0);
        chk("sclr_pkt", pkt_cnt, 6);
        tick();
        out_ready = 1'b1;
        run(8, rd, vld, mr, lr);
        tick();
        chk("sclr_beats", rx_n - base, 1);
        chk_beat(base, pw(43), 1, 1);
        chk("sclr_pkt_after", pkt_cnt, 7);

        // Async reset mid-packet with the buffer full
        out_ready = 1'b0;
        hdr(6);
        for (int k = 0; k < 6; k++) push(pw(50 + k));
        run(4, rd, vld, mr, lr);
        chk("ar_pre_valid", out_valid, 1);
        chk("ar_pre_rdreq", fifo_rdreq, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_sop", out_sop, 0);
        chk("ar_eop", out_eop, 0);
        chk("ar_pkt", pkt_cnt, 0);
        chk("ar_err", err_zero_len, 0);
        chk("ar_rdreq", fifo_rdreq, 0);
        wr_ptr = rd_ptr;
        tick();
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
